// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the iterative multiply sequencer and its execute-stage neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_mul_sequencer_pkg;

    // Execute-stage ALU function codes.
    localparam logic [3:0] ALU_ADD_UNSIGNED_FUNCTION = 4'd0;
    localparam logic [3:0] ALU_ADD_SIGNED_FUNCTION   = 4'd1;
    localparam logic [3:0] ALU_SUB_FUNCTION          = 4'd2;
    localparam logic [3:0] ALU_AND_FUNCTION          = 4'd3;
    localparam logic [3:0] ALU_OR_FUNCTION           = 4'd4;
    localparam logic [3:0] ALU_XOR_FUNCTION          = 4'd5;

    // Sequencer state encodings.
    typedef enum logic [1:0] {
        MULSEQ_IDLE = 2'd0,
        MULSEQ_RUN  = 2'd1,
        MULSEQ_DONE = 2'd2
    } mulseq_state_t;

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 32x32 MUL (low word), borrowing the execute-stage adder for accumulate steps.
// Latency: k+1 cycles start->done for k iterations (1 if multiplier is 0 with early termination).
// Backpressure: a cycle needing the adder without alu_gnt stalls every register in place.
module alu_mul_sequencer
    import alu_mul_sequencer_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             alu_req,
    input  logic             alu_gnt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_func,
    output logic             alu_c_in,
    input  logic [WIDTH-1:0] alu_out
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    mulseq_state_t    state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [CNT_W-1:0] cnt;

    // An iteration can retire when it needs no add, or the add has been granted.
    logic             step_ok;
    logic [WIDTH-1:0] mplr_next;

    assign step_ok   = !mplr[0] || alu_gnt;
    assign mplr_next = mplr >> 1;

    // The adder is only requested for accumulate steps; operands are always acc + mcand.
    assign busy     = (state != MULSEQ_IDLE);
    assign alu_req  = (state == MULSEQ_RUN) && mplr[0];
    assign alu_a    = acc;
    assign alu_b    = mcand;
    assign alu_func = ALU_ADD_UNSIGNED_FUNCTION;
    assign alu_c_in = 1'b0;

    // Sequencer FSM with datapath registers and registered result/flags/done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= MULSEQ_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplr   <= '0;
            cnt    <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // Abandon the multiply; result keeps its previous value.
                state <= MULSEQ_IDLE;
            end else begin
                case (state)
                    MULSEQ_IDLE: begin
                        if (start) begin
                            acc   <= '0;
                            mcand <= op_a;
                            mplr  <= op_b;
                            cnt   <= '0;
                            if (EARLY_TERM && (op_b == '0)) begin
                                state <= MULSEQ_DONE;
                            end else begin
                                state <= MULSEQ_RUN;
                            end
                        end
                    end
                    MULSEQ_RUN: begin
                        if (step_ok) begin
                            if (mplr[0]) begin
                                acc <= alu_out;
                            end
                            mcand <= mcand << 1;
                            mplr  <= mplr_next;
                            cnt   <= cnt + CNT_W'(1);
                            if ((cnt == CNT_LAST) || (EARLY_TERM && (mplr_next == '0))) begin
                                state <= MULSEQ_DONE;
                            end
                        end
                    end
                    MULSEQ_DONE: begin
                        result <= acc;
                        flag_n <= acc[WIDTH-1];
                        flag_z <= (acc == '0);
                        done   <= 1'b1;
                        state  <= MULSEQ_IDLE;
                    end
                    default: begin
                        state <= MULSEQ_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;
    import alu_mul_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        flag_n;
    logic        flag_z;
    logic        alu_req;
    logic        alu_gnt;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_func;
    logic        alu_c_in;
    logic [31:0] alu_out;

    int n_tests = 0;
    int n_fail  = 0;

    alu_mul_sequencer #(.WIDTH(32), .EARLY_TERM(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .flush    (flush),
        .op_a     (op_a),
        .op_b     (op_b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .flag_n   (flag_n),
        .flag_z   (flag_z),
        .alu_req  (alu_req),
        .alu_gnt  (alu_gnt),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_func (alu_func),
        .alu_c_in (alu_c_in),
        .alu_out  (alu_out)
    );

    // Execute-stage adder model: plain wrapping sum.
    assign alu_out = alu_a + alu_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one multiply from a point just after a rising edge and follow it to done.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int stalls,
                           input bit mid_start, output logic [31:0] res, output logic n,
                           output logic z, output int lat, output int reqs, output bit timed_out);
        int stall_left;
        stall_left = stalls;
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; reqs = 0; timed_out = 1'b1;
        res = '0; n = 1'b0; z = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                res = result; n = flag_n; z = flag_z; timed_out = 1'b0;
                break;
            end
            if (alu_req) reqs++;
            if (alu_req && stall_left > 0) begin
                alu_gnt = 1'b0;
                stall_left--;
            end else begin
                alu_gnt = 1'b1;
            end
            if (mid_start && i == 2) begin
                start = 1'b1; op_a = 32'd100; op_b = 32'd100;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        alu_gnt = 1'b1;
        start   = 1'b0;
        if (timed_out) begin
            n_tests++; n_fail++;
            $display("FAIL timeout: no done within 200 cycles for %h*%h", a, b);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; alu_gnt = 1'b1;
        op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({busy, done, flag_n, flag_z, alu_req, alu_c_in} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {busy, done, flag_n, flag_z, alu_req, alu_c_in});
        end
        n_tests++;
        if (result !== 32'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: result=%h alu_a=%h alu_b=%h required 0", result, alu_a, alu_b);
        end
        n_tests++;
        if (alu_func !== ALU_ADD_UNSIGNED_FUNCTION) begin
            n_fail++;
            $display("FAIL alu_func: got %h required %h", alu_func, ALU_ADD_UNSIGNED_FUNCTION);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] r; logic n, z; int lat, reqs; bit to;
        run_mul(32'd3, 32'd5, 0, 1'b0, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'd15 || n !== 1'b0 || z !== 1'b0) begin
            n_fail++; $display("FAIL mul_3x5: got %0d n=%b z=%b required 15 n=0 z=0", r, n, z);
        end
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL lat_3x5: got %0d required 4", lat); end
        n_tests++;
        if (reqs !== 2) begin n_fail++; $display("FAIL req_3x5: got %0d required 2", reqs); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done: got %b required 0", busy); end
    endtask

    task automatic test_full_width();
        logic [31:0] r; logic n, z; int lat, reqs; bit to;
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'h0000_0001 || n !== 1'b0 || z !== 1'b0) begin
            n_fail++; $display("FAIL mul_ffff: got %h n=%b z=%b required 00000001 n=0 z=0", r, n, z);
        end
        n_tests++;
        if (lat !== 33) begin n_fail++; $display("FAIL lat_ffff: got %0d required 33", lat); end
        n_tests++;
        if (reqs !== 32) begin n_fail++; $display("FAIL req_ffff: got %0d required 32", reqs); end
    endtask

    task automatic test_zero_mplr();
        logic [31:0] r; logic n, z; int lat, reqs; bit to;
        run_mul(32'h0000_1234, 32'h0, 0, 1'b0, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'h0 || z !== 1'b1 || n !== 1'b0) begin
            n_fail++; $display("FAIL mul_zero: got %h n=%b z=%b required 0 n=0 z=1", r, n, z);
        end
        n_tests++;
        if (lat !== 1) begin n_fail++; $display("FAIL lat_zero: got %0d required 1", lat); end
        n_tests++;
        if (reqs !== 0) begin n_fail++; $display("FAIL req_zero: got %0d required 0", reqs); end
    endtask

    task automatic test_top_bit();
        logic [31:0] r; logic n, z; int lat, reqs; bit to;
        run_mul(32'd7, 32'h8000_0000, 0, 1'b0, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'h8000_0000 || n !== 1'b1 || z !== 1'b0) begin
            n_fail++; $display("FAIL mul_top: got %h n=%b z=%b required 80000000 n=1 z=0", r, n, z);
        end
        n_tests++;
        if (lat !== 33) begin n_fail++; $display("FAIL lat_top: got %0d required 33", lat); end
        n_tests++;
        if (reqs !== 1) begin n_fail++; $display("FAIL req_top: got %0d required 1", reqs); end
    endtask

    task automatic test_stall();
        logic [31:0] r; logic n, z; int lat, reqs; bit to;
        run_mul(32'd3, 32'd5, 4, 1'b1, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'd15) begin n_fail++; $display("FAIL mul_stall: got %0d required 15", r); end
        n_tests++;
        if (lat !== 8) begin n_fail++; $display("FAIL lat_stall: got %0d required 8", lat); end
        // The ignored mid-run start must not have launched another operation.
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_start_ignored: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r; logic n, z; int lat, reqs; bit to;
        run_mul(32'd9, 32'd3, 0, 1'b0, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'd27 || lat !== 3) begin
            n_fail++; $display("FAIL b2b_first: got %0d lat=%0d required 27 lat=3", r, lat);
        end
        // Start issued in the done cycle itself.
        run_mul(32'hFFFF_FFFE, 32'd2, 0, 1'b0, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'hFFFF_FFFC || n !== 1'b1 || lat !== 3) begin
            n_fail++; $display("FAIL b2b_second: got %h n=%b lat=%0d required fffffffc n=1 lat=3", r, n, lat);
        end
    endtask

    task automatic check_abort(input string tag, input logic [31:0] exp_res);
        int dones;
        logic [31:0] r; logic n, z; int lat, reqs; bit to;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL %s_idle: busy=%b done=%b required 0 0", tag, busy, done);
        end
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (dones !== 0 || result !== exp_res) begin
            n_fail++; $display("FAIL %s_nodone: dones=%0d result=%h required 0 %h", tag, dones, result, exp_res);
        end
        run_mul(32'd6, 32'd7, 0, 1'b0, r, n, z, lat, reqs, to);
        n_tests++;
        if (r !== 32'd42 || lat !== 4) begin
            n_fail++; $display("FAIL %s_after: got %0d lat=%0d required 42 lat=4", tag, r, lat);
        end
    endtask

    task automatic test_flush();
        // Previous result is 0xFFFFFFFC from the back-to-back test.
        start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        flush = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        check_abort("flush", 32'hFFFF_FFFC);
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_abort("rst", 32'h0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_width();
        test_zero_mplr();
        test_top_bit();
        test_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
